// File: rtl/insight_tl_pkg.sv
// ---------------------------------------------------------------------------
// insight_tl_pkg
// Shared definitions for the Insight TileLink D-channel capture path:
//   - d_opcode_e     : TileLink D-channel opcodes
//   - rec_hdr_t      : fixed-width part of a captured beat record
//   - is_data_opcode : true for the data-bearing D opcodes
//   - beats_for      : beats in a response of lg2 size `size` on a data_w bus
// ---------------------------------------------------------------------------
package insight_tl_pkg;

    typedef enum logic [2:0] {
        D_ACCESS_ACK      = 3'd0,
        D_ACCESS_ACK_DATA = 3'd1,
        D_HINT_ACK        = 3'd2,
        D_GRANT           = 3'd4,
        D_GRANT_DATA      = 3'd5,
        D_RELEASE_ACK     = 3'd6
    } d_opcode_e;

    localparam int OPCODE_W = 3;
    localparam int PARAM_W  = 2;
    localparam int SIZE_W   = 4;
    localparam int DROP_W   = 16;
    localparam int TS_W     = 32;

    // Fields of a record whose widths do not depend on the bus parameters.
    // The parametrised fields (source, sink, beat, data, timestamp) are
    // appended by the capture unit.
    typedef struct packed {
        logic [OPCODE_W-1:0] opcode;
        logic [PARAM_W-1:0]  param;
        logic [SIZE_W-1:0]   size;
        logic                denied;
        logic                corrupt;
        logic                last;
    } rec_hdr_t;

    function automatic logic is_data_opcode(input logic [OPCODE_W-1:0] opcode);
        return (opcode == D_ACCESS_ACK_DATA) || (opcode == D_GRANT_DATA);
    endfunction

    // Transfers smaller than one bus word still occupy a single beat.
    function automatic int beats_for(input logic [SIZE_W-1:0] size, input int data_w);
        int bytes;
        int total;
        bytes = data_w / 8;
        total = 1 << size;
        if (total <= bytes) begin
            return 1;
        end
        return total / bytes;
    endfunction

endpackage

// File: rtl/insight_tl_fifo.sv
// ---------------------------------------------------------------------------
// insight_tl_fifo
// Generic DEPTH x WIDTH synchronous FIFO, no bypass (a push becomes visible
// the cycle after it is written). A push while full is accepted only when a
// pop happens in the same cycle; otherwise it is ignored and the caller is
// expected to account for the drop.
// Ports:
//   clock, reset     : clock, asynchronous active-high reset (empties FIFO)
//   push, wr_data    : write request and data
//   pop              : read request (ignored when empty)
//   rd_data          : head entry (valid while !empty)
//   full, empty      : occupancy flags
// ---------------------------------------------------------------------------
module insight_tl_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    // One extra wrap bit on each pointer separates full from empty.
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        do_push;
    logic        do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop & ~empty;
    // When full, the slot being written is the one being popped this cycle.
    assign do_push = push & (~full | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

    assign rd_data = mem[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/insight_tl_d_capture.sv
// ---------------------------------------------------------------------------
// insight_tl_d_capture
// Passive TileLink D-channel capture unit for the Insight trace path.
// Observes every D-channel fire (d_valid & d_ready), tags each beat with its
// index inside the response and a last flag, and queues the beat record in a
// DEPTH-entry FIFO drained through the out_valid/out_ready port. Beats that
// arrive while the FIFO is full (and not popping) are dropped and counted.
// A burst interrupted by a beat with different opcode/size/source, or a
// data-bearing beat with size above MAX_SIZE, raises a one-cycle burst_err.
//
// Optional build macro: INSIGHT_TL_D_CAPTURE_TIMESTAMP_EN
//   When defined, a free-running 32-bit cycle counter is stored in every
//   record and presented on the extra output out_timestamp.
//
// Ports:
//   clock, reset           : clock, asynchronous active-high reset
//   d_*                    : snooped D-channel signals (inputs only)
//   out_valid/out_ready    : record handshake towards the trace sink
//   out_*                  : head record fields (zero while out_valid is low)
//   out_beat, out_last     : beat index within the response, final beat flag
//   drop_count             : saturating count of beats dropped on full FIFO
//   burst_err              : one-cycle pulse on a burst protocol violation
// ---------------------------------------------------------------------------
module insight_tl_d_capture
    import insight_tl_pkg::*;
#(
    parameter  int DATA_W   = 32,
    parameter  int SOURCE_W = 1,
    parameter  int SINK_W   = 1,
    parameter  int DEPTH    = 4,
    parameter  int MAX_SIZE = 6,
    localparam int LG_BYTES = $clog2(DATA_W / 8),
    localparam int BEAT_W   = ((MAX_SIZE - LG_BYTES) > 1) ? (MAX_SIZE - LG_BYTES) : 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                d_valid,
    input  logic                d_ready,
    input  logic [2:0]          d_opcode,
    input  logic [1:0]          d_param,
    input  logic [3:0]          d_size,
    input  logic [SOURCE_W-1:0] d_source,
    input  logic [SINK_W-1:0]   d_sink,
    input  logic                d_denied,
    input  logic                d_corrupt,
    input  logic [DATA_W-1:0]   d_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2:0]          out_opcode,
    output logic [1:0]          out_param,
    output logic [3:0]          out_size,
    output logic [SOURCE_W-1:0] out_source,
    output logic [SINK_W-1:0]   out_sink,
    output logic                out_denied,
    output logic                out_corrupt,
    output logic [DATA_W-1:0]   out_data,
    output logic [BEAT_W-1:0]   out_beat,
    output logic                out_last,
`ifdef INSIGHT_TL_D_CAPTURE_TIMESTAMP_EN
    output logic [31:0]         out_timestamp,
`endif
    output logic [15:0]         drop_count,
    output logic                burst_err
);

    typedef struct packed {
        rec_hdr_t            hdr;
        logic [SOURCE_W-1:0] source;
        logic [SINK_W-1:0]   sink;
        logic [BEAT_W-1:0]   beat;
        logic [DATA_W-1:0]   data;
`ifdef INSIGHT_TL_D_CAPTURE_TIMESTAMP_EN
        logic [TS_W-1:0]     timestamp;
`endif
    } rec_t;

    localparam int REC_W = $bits(rec_t);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [2:0]          lat_opcode_q, lat_opcode_d;
    logic [3:0]          lat_size_q, lat_size_d;
    logic [SOURCE_W-1:0] lat_source_q, lat_source_d;
    logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [BEAT_W-1:0]   last_idx_q, last_idx_d;
    logic                burst_err_q, burst_err_d;
    logic [15:0]         drop_count_q, drop_count_d;

    logic                fire;
    logic                data_op;
    logic                oversize;
    int                  beats_int;
    logic [BEAT_W-1:0]   new_last_idx;
    logic                mismatch;
    logic                violation;
    logic                start_new;
    logic [BEAT_W-1:0]   rec_beat;
    logic                rec_last;

    rec_t                rec_in;
    rec_t                rec_out;
    logic [REC_W-1:0]    fifo_rd;
    logic                fifo_full;
    logic                fifo_empty;
    logic                pop;
    logic                drop;

    assign fire     = d_valid & d_ready;
    assign data_op  = is_data_opcode(d_opcode);
    assign oversize = data_op && (int'(d_size) > MAX_SIZE);

    // Oversized data responses are clamped to the largest representable burst
    // so the beat counter still tracks the bus.
    always_comb begin
        beats_int = 1;
        if (data_op) begin
            beats_int = oversize ? (1 << BEAT_W) : beats_for(d_size, DATA_W);
        end
    end

    assign new_last_idx = BEAT_W'(beats_int - 1);
    assign mismatch     = (d_opcode != lat_opcode_q) || (d_size != lat_size_q) ||
                          (d_source != lat_source_q);

    // Burst tracking. Every fire advances the FSM, whether or not the beat
    // finds room in the FIFO.
    always_comb begin
        state_d      = state_q;
        lat_opcode_d = lat_opcode_q;
        lat_size_d   = lat_size_q;
        lat_source_d = lat_source_q;
        beat_cnt_d   = beat_cnt_q;
        last_idx_d   = last_idx_q;
        rec_beat     = '0;
        rec_last     = 1'b0;
        violation    = 1'b0;
        start_new    = 1'b0;

        if (fire) begin
            case (state_q)
                ST_IDLE: begin
                    start_new = 1'b1;
                end
                ST_BURST: begin
                    if (mismatch) begin
                        // Abandon the burst; the offending beat opens a new response.
                        violation = 1'b1;
                        start_new = 1'b1;
                    end else begin
                        rec_beat = beat_cnt_q;
                        if (beat_cnt_q == last_idx_q) begin
                            rec_last   = 1'b1;
                            state_d    = ST_IDLE;
                            beat_cnt_d = '0;
                        end else begin
                            beat_cnt_d = beat_cnt_q + BEAT_W'(1);
                        end
                    end
                end
                default: begin
                    start_new = 1'b1;
                end
            endcase

            if (start_new) begin
                rec_beat = '0;
                if (new_last_idx != '0) begin
                    state_d      = ST_BURST;
                    lat_opcode_d = d_opcode;
                    lat_size_d   = d_size;
                    lat_source_d = d_source;
                    beat_cnt_d   = BEAT_W'(1);
                    last_idx_d   = new_last_idx;
                end else begin
                    state_d    = ST_IDLE;
                    beat_cnt_d = '0;
                    rec_last   = 1'b1;
                end
            end
        end

        burst_err_d = violation | (fire & oversize);
    end

    assign out_valid = ~fifo_empty;
    assign pop       = out_valid & out_ready;
    assign drop      = fire & fifo_full & ~pop;

    always_comb begin
        drop_count_d = drop_count_q;
        if (drop && (drop_count_q != 16'hFFFF)) begin
            drop_count_d = drop_count_q + 16'd1;
        end
    end

`ifdef INSIGHT_TL_D_CAPTURE_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q, ts_d;

    assign ts_d = ts_q + TS_W'(1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_d;
        end
    end
`endif

    always_comb begin
        rec_in             = '0;
        rec_in.hdr.opcode  = d_opcode;
        rec_in.hdr.param   = d_param;
        rec_in.hdr.size    = d_size;
        rec_in.hdr.denied  = d_denied;
        rec_in.hdr.corrupt = d_corrupt;
        rec_in.hdr.last    = rec_last;
        rec_in.source      = d_source;
        rec_in.sink        = d_sink;
        rec_in.beat        = rec_beat;
        rec_in.data        = d_data;
`ifdef INSIGHT_TL_D_CAPTURE_TIMESTAMP_EN
        rec_in.timestamp   = ts_q;
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            lat_opcode_q <= '0;
            lat_size_q   <= '0;
            lat_source_q <= '0;
            beat_cnt_q   <= '0;
            last_idx_q   <= '0;
            burst_err_q  <= 1'b0;
            drop_count_q <= '0;
        end else begin
            state_q      <= state_d;
            lat_opcode_q <= lat_opcode_d;
            lat_size_q   <= lat_size_d;
            lat_source_q <= lat_source_d;
            beat_cnt_q   <= beat_cnt_d;
            last_idx_q   <= last_idx_d;
            burst_err_q  <= burst_err_d;
            drop_count_q <= drop_count_d;
        end
    end

    insight_tl_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (fire),
        .pop     (pop),
        .wr_data (rec_in),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Masking with out_valid keeps the record fields at zero when nothing is
    // queued (including straight out of reset), since the storage is unreset.
    assign rec_out = out_valid ? rec_t'(fifo_rd) : '0;

    assign out_opcode  = rec_out.hdr.opcode;
    assign out_param   = rec_out.hdr.param;
    assign out_size    = rec_out.hdr.size;
    assign out_denied  = rec_out.hdr.denied;
    assign out_corrupt = rec_out.hdr.corrupt;
    assign out_last    = rec_out.hdr.last;
    assign out_source  = rec_out.source;
    assign out_sink    = rec_out.sink;
    assign out_beat    = rec_out.beat;
    assign out_data    = rec_out.data;
`ifdef INSIGHT_TL_D_CAPTURE_TIMESTAMP_EN
    assign out_timestamp = rec_out.timestamp;
`endif

    assign drop_count = drop_count_q;
    assign burst_err  = burst_err_q;

endmodule

// File: doc/insight_tl_d_capture.md
Name: insight_tl_d_capture

Overview:
- Passive, parametrised TileLink D-channel capture unit for the Insight trace path.
- Snoops any hart D channel (instruction or data) without affecting the ready/valid handshake.
- Tracks multi-beat bursts and tags each beat with its index and a last flag.
- Buffers beat records in a DEPTH-entry FIFO drained by the trace sink through a ready/valid port; counts dropped beats.

Parameters:
- DATA_W, 32: D-channel data width in bits; power of 2, minimum 8.
- SOURCE_W, 1: width of d_source.
- SINK_W, 1: width of d_sink.
- DEPTH, 4: capture FIFO entries; power of 2, minimum 2.
- MAX_SIZE, 6: largest legal lg2 transfer size; sets BEAT_W = max(1, MAX_SIZE - lg2(DATA_W/8)).

Ports:
- clock  in  1  single clock.
- reset  in  1  asynchronous, active-high reset.
- d_valid  in  1  snooped D valid.
- d_ready  in  1  snooped D ready.
- d_opcode  in  3  snooped opcode.
- d_param  in  2  snooped param.
- d_size  in  4  snooped lg2 transfer size.
- d_source  in  SOURCE_W  snooped source ID.
- d_sink  in  SINK_W  snooped sink ID.
- d_denied  in  1  snooped denied.
- d_corrupt  in  1  snooped corrupt.
- d_data  in  DATA_W  snooped data.
- out_valid  out  1  record available.
- out_ready  in  1  sink accepts record.
- out_opcode  out  3  captured opcode.
- out_param  out  2  captured param.
- out_size  out  4  captured size.
- out_source  out  SOURCE_W  captured source.
- out_sink  out  SINK_W  captured sink.
- out_denied  out  1  captured denied.
- out_corrupt  out  1  captured corrupt.
- out_data  out  DATA_W  captured data.
- out_beat  out  BEAT_W  beat index within the response.
- out_last  out  1  final beat of the response.
- drop_count  out  16  saturating count of beats dropped on full FIFO.
- burst_err  out  1  one-cycle pulse on a burst protocol violation.

Behaviour:
- Signal definitions:
  - fire = d_valid & d_ready.
  - Data-bearing opcodes: AccessAckData (1), GrantData (5).
  - beats = data-bearing ? max(1, 2^d_size / (DATA_W/8)) : 1.
- Burst FSM, 2 states:
  - IDLE: on fire with beats > 1, latch opcode, size and source; beat_cnt <= 1; go to BURST.
  - IDLE: on fire with beats == 1, record beat 0 with last = 1; stay in IDLE.
  - BURST: each fire records beat = beat_cnt; beat_cnt increments.
  - BURST: when beat_cnt == beats-1, that beat has last = 1, then go to IDLE.
- Burst violation: in BURST, a fire whose opcode, size or source differs from the latched values.
  - burst_err pulses high the cycle after the fire.
  - The violating beat is treated as a new response: handled exactly as a fire in IDLE.
  - The aborted burst's prior beats stay in the FIFO, none carrying last.
- d_size > MAX_SIZE on a data-bearing fire: burst_err pulses; beats clamps to 2^BEAT_W.
- FIFO:
  - Push on fire; record visible at out_valid the cycle after the fire (1-cycle latency).
  - Pop on out_valid & out_ready.
  - out_* hold stable while out_valid & !out_ready.
  - Full with no pop: beat dropped, drop_count += 1, saturating at 0xFFFF.
  - Full with simultaneous pop: push accepted, nothing dropped.
  - Empty with push: no bypass; out_valid rises the next cycle.
  - Pointers wrap modulo DEPTH; an extra wrap bit distinguishes full from empty.
- A dropped beat still advances beat_cnt, so the burst FSM stays in step with the bus.
- Reset (asynchronous assert, any time including mid-burst):
  - FSM returns to IDLE; beat_cnt = 0; FIFO empties.
  - Outputs: out_valid = 0, drop_count = 0, burst_err = 0, all out_* data fields 0.
- The block never drives d_ready; it is observation-only.

Optional Feature:
- Macro: INSIGHT_TL_D_CAPTURE_TIMESTAMP_EN.
- Defined:
  - A free-running 32-bit cycle counter, reset to 0, wraps at 2^32.
  - Each record stores the counter value at its fire cycle.
  - New output port out_timestamp, 32 bits.
- Undefined: no counter, no out_timestamp port, FIFO entry width unchanged otherwise.

Decomposition:
- Package insight_tl_pkg:
  - D opcode enum (AccessAck, AccessAckData, HintAck, Grant, GrantData, ReleaseAck).
  - Function is_data_opcode.
  - Function beats_for(size, DATA_W).
  - Parametrised record struct fields list.
- Sub-module insight_tl_fifo: generic DEPTH x WIDTH synchronous FIFO with full/empty, push/pop and same-cycle push+pop when full.

Test Plan:
- Single AccessAck (opcode 0, size 2, source 1) fire -> next cycle out_valid = 1, out_beat = 0, out_last = 1, out_opcode = 0.
- AccessAckData, DATA_W = 32, size 4: four fires with data A0..A3 -> four records, out_beat 0,1,2,3, out_last only on beat 3, data in order.
- out_ready held 0 with DEPTH = 4, six single-beat fires -> four records retained, drop_count = 2; fifth fire coincident with the first pop is accepted instead.
- Burst size 4 interrupted after beat 1 by a fire with a different source -> burst_err pulse one cycle; interrupting record has beat 0; no last on beats 0 and 1 of the aborted burst.
- Reset asserted mid-burst after beat 2 with 3 records queued -> out_valid = 0 immediately; the next fire produces beat 0.
- With INSIGHT_TL_D_CAPTURE_TIMESTAMP_EN defined: fires at cycles 10 and 13 after reset -> out_timestamp 10 then 13.
